vector_alu_pipe: RTL
====================

# vector_alu_pipe

Pipelined, parametrised vector ALU. Second generation of the single-cycle add/multiply vector unit. Generalised in lane count, lane width and opcode set, with a valid/ready handshake and full-pipeline backpressure. Sits between the vector register-file read port and the writeback stage. Like its predecessor, it returns a double-width result per lane split into hi/lo words, plus a 2-bit condition code per lane.

## Interface
- LANES, 16, number of independent lanes
- WIDTH, 32, signed operand width per lane
- MUL_STAGES, 2, multiplier pipeline depth (≥1); total latency LAT = MUL_STAGES + 1
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand vector presented
- in_ready  out  1  unit can accept this cycle
- opcode  in  2  00 add, 01 sub (op1−op2), 10 mul, 11 pass op1 (sign-extended)
- operand1, operand2  in  LANES*WIDTH  packed lanes; lane i at [WIDTH*i +: WIDTH], two's complement
- out_valid  out  1  result vector valid
- out_ready  in  1  consumer accepts result
- result_lo  out  LANES*WIDTH  low WIDTH bits of each lane's exact result
- result_hi  out  LANES*WIDTH  high WIDTH bits of each lane's exact result
- cc  out  2*LANES  per-lane code at [2i+1:2i]
- busy  out  1  any pipeline stage holds a valid entry

## Operation
- Each lane computes the exact 2*WIDTH-bit signed result {hi, lo} from two sign-extended WIDTH-bit operands.
- Add/sub/pass never exceed WIDTH+1 bits. Mul is exact within 2*WIDTH.
- cc, evaluated on the exact result R:
  - 11 if R ≠ sign-extension of lo (does not fit in WIDTH)
  - else 00 if R = 0, 01 if R < 0, 10 if R > 0
- All opcodes traverse the same LAT stages. Add/sub/pass are computed in stage 1 and delayed, so results stay in issue order.
- Opcode is captured with the operands. Changing opcode between transfers has no effect on in-flight data.
- Handshake:
  - A transfer occurs when in_valid & in_ready; out consumption when out_valid & out_ready.
  - The pipeline advances as a whole when `advance = ~out_valid | out_ready`.
  - in_ready = advance, combinational from out_ready and out_valid only, never from in_valid.
  - When the pipeline is stalled, all stage registers and outputs hold. The output is stable while out_valid & ~out_ready.
- Bubbles: stages carry a valid bit. Invalid stages advance, so bubbles collapse only at the output register.
- Reset mid-operation discards all in-flight entries; no partial result is ever presented.

## Timing
- Reset values: out_valid=0, result_lo=0, result_hi=0, cc=00 on all lanes, busy=0, all stage valid bits 0. in_ready=1 while out_valid=0.
- Latency: an operand accepted at edge k produces out_valid=1 after edge k+LAT, absent stalls.
- Throughput: one vector per cycle with out_ready held high.
- Simultaneous output consumption and new acceptance in the same cycle is legal and loses no data.
- out_ready low for N cycles with a full pipeline: exactly LAT entries are held and in_ready=0. After release, entries drain in order, one per cycle.
- busy = OR of all stage valid bits, including the output stage.

## Configuration
- VALU_SAT_EN: when defined, adds input port `sat` (1 bit), captured with the operands.
  - With sat=1, any lane with cc=11 has result_lo clamped to the signed WIDTH max (R>0) or min (R<0).
  - result_hi and cc still reflect the exact result.
- Without the macro there is no `sat` port; result_lo is always the raw low word.
- Latency is identical in both builds.

## Structure
- Shared package valu_pkg holds:
  - opcode typedef and its four constants
  - cc constants CC_ZERO=00, CC_NEG=01, CC_POS=10, CC_OVF=11
- Sub-module valu_lane: one lane's datapath, multiplier pipeline, cc and saturation logic, with a shared stall enable. Instantiated LANES times by generate.
- Top level owns the valid bits, handshake and busy.

## Test plan
- Reset: assert rst mid-stream with 2 entries in flight → out_valid=0, results/cc zero, busy=0 next cycle. No stale output after rst falls.
- Add, LANES=16, WIDTH=32: lane0 7+(−7), lane1 −5+2, lane2 0x7FFFFFFF+1 → lane0 cc 00; lane1 lo 0xFFFFFFFD cc 01; lane2 hi 0x00000000, lo 0x80000000, cc 11. Appears exactly LAT=3 cycles after acceptance.
- Mul: 0x10000×0x10000 → hi 0x00000001, lo 0, cc 11. −3×4 → hi 0xFFFFFFFF, lo 0xFFFFFFF4, cc 01.
- Back-to-back add, mul, sub, pass with out_ready=1 → four consecutive out_valid cycles, results in issue order.
- Backpressure: out_ready=0 for 5 cycles while in_valid=1 → in_ready drops after 3 accepts. Output holds stable. After release, 3 results drain in order with no loss or duplication.
- VALU_SAT_EN build, sat=1: 0x7FFFFFFF+1 → lo 0x7FFFFFFF, cc 11. Mul −0x40000000×4 → lo 0x80000000, cc 11.

Source files
------------

// File: rtl/valu_pkg.sv
// valu_pkg: shared types and constants for the pipelined vector ALU.
//   valu_op_e : lane opcode (add, sub, mul, pass op1)
//   CC_*      : per-lane condition codes evaluated on the exact double-width result
// Optional feature macro used by the design: VALU_SAT_EN (see vector_alu_pipe).
package valu_pkg;

    typedef enum logic [1:0] {
        OpAdd  = 2'b00,
        OpSub  = 2'b01,
        OpMul  = 2'b10,
        OpPass = 2'b11
    } valu_op_e;

    localparam logic [1:0] CC_ZERO = 2'b00;
    localparam logic [1:0] CC_NEG  = 2'b01;
    localparam logic [1:0] CC_POS  = 2'b10;
    localparam logic [1:0] CC_OVF  = 2'b11;

endpackage

// File: rtl/valu_lane.sv
// valu_lane: one lane of the vector ALU, MUL_STAGES+1 register stages deep.
//   Stage 1 captures operands, opcode and sat, and computes add/sub/pass.
//   The multiply runs off the stage-1 operands; MUL_STAGES-1 delay registers follow,
//   then the output register holds {hi, lo} and the condition code.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   en              shared pipeline advance; every register holds when low
//   op, sat         opcode and clamp request, captured with the operands
//   a, b            signed WIDTH-bit operands
//   res_lo, res_hi  low/high words of the exact 2*WIDTH-bit result (lo clamped if sat)
//   cc              condition code of the exact result
module valu_lane
    import valu_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  valu_op_e         op,
    input  logic             sat,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic [1:0]       cc
);
    localparam int unsigned DW = 2 * WIDTH;

    logic [DW-1:0]    a_ext, b_ext, lin;
    logic [WIDTH-1:0] a_q, b_q;
    valu_op_e         op_q;
    logic             sat_q;
    logic [DW-1:0]    lin_q, a_q_ext, b_q_ext, prod, mid;
    logic [DW:0]      fin;  // {sat, exact result} entering the output register

    assign a_ext = {{WIDTH{a[WIDTH-1]}}, a};
    assign b_ext = {{WIDTH{b[WIDTH-1]}}, b};

    always_comb begin
        lin = a_ext;
        case (op)
            OpAdd:   lin = a_ext + b_ext;
            OpSub:   lin = a_ext - b_ext;
            default: lin = a_ext;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= OpAdd;
            sat_q <= 1'b0;
            lin_q <= '0;
        end else if (en) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op;
            sat_q <= sat;
            lin_q <= lin;
        end
    end

    // Low DW bits of the product of sign-extended operands are the exact signed product.
    assign a_q_ext = {{WIDTH{a_q[WIDTH-1]}}, a_q};
    assign b_q_ext = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    assign prod    = a_q_ext * b_q_ext;
    assign mid     = (op_q == OpMul) ? prod : lin_q;

    if (MUL_STAGES == 1) begin : g_no_dly
        assign fin = {sat_q, mid};
    end else begin : g_dly
        logic [DW:0] dly_q [MUL_STAGES-1];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < int'(MUL_STAGES) - 1; i++) dly_q[i] <= '0;
            end else if (en) begin
                dly_q[0] <= {sat_q, mid};
                for (int i = 1; i < int'(MUL_STAGES) - 1; i++) dly_q[i] <= dly_q[i-1];
            end
        end

        assign fin = dly_q[MUL_STAGES-2];
    end

    logic [DW-1:0]    exact;
    logic             sat_f, fits;
    logic [WIDTH-1:0] lo_d;
    logic [1:0]       cc_d;

    assign {sat_f, exact} = fin;
    assign fits = (exact == {{WIDTH{exact[WIDTH-1]}}, exact[WIDTH-1:0]});

    always_comb begin
        lo_d = exact[WIDTH-1:0];
        cc_d = CC_POS;
        if (!fits) begin
            cc_d = CC_OVF;
            if (sat_f) begin
                lo_d = exact[DW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            end
        end else if (exact == '0) begin
            cc_d = CC_ZERO;
        end else if (exact[DW-1]) begin
            cc_d = CC_NEG;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_lo <= '0;
            res_hi <= '0;
            cc     <= CC_ZERO;
        end else if (en) begin
            res_lo <= lo_d;
            res_hi <= exact[DW-1:WIDTH];
            cc     <= cc_d;
        end
    end

endmodule

// File: rtl/vector_alu_pipe.sv
// vector_alu_pipe: pipelined LANES-wide signed vector ALU with valid/ready handshake.
// The whole pipeline (LAT = MUL_STAGES+1 register stages, the last being the output
// register) advances together when the output is empty or being consumed.
// Operands presented in the cycle after edge k are captured at edge k+1 and appear
// after edge k+LAT.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid, in_ready    input handshake; in_ready depends only on out_valid/out_ready
//   opcode                00 add, 01 sub, 10 mul, 11 pass op1
//   operand1, operand2    packed lanes, lane i at [WIDTH*i +: WIDTH]
//   sat                   (VALU_SAT_EN builds only) clamp lo of overflowing lanes
//   out_valid, out_ready  output handshake
//   result_lo, result_hi  low/high words of each lane's exact result
//   cc                    per-lane condition code at [2i+1:2i]
//   busy                  any stage holds a valid entry
// Macro: VALU_SAT_EN adds the sat port and enables saturation of result_lo.
module vector_alu_pipe
    import valu_pkg::*;
#(
    parameter int unsigned LANES      = 16,
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             opcode,
    input  logic [LANES*WIDTH-1:0] operand1,
    input  logic [LANES*WIDTH-1:0] operand2,
`ifdef VALU_SAT_EN
    input  logic                   sat,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] result_lo,
    output logic [LANES*WIDTH-1:0] result_hi,
    output logic [2*LANES-1:0]     cc,
    output logic                   busy
);
    localparam int unsigned LAT = MUL_STAGES + 1;

    logic [LAT-1:0] valid_q;
    logic           advance, sat_in;
    valu_op_e       op_in;

    assign advance   = ~valid_q[LAT-1] | out_ready;
    assign in_ready  = advance;
    assign out_valid = valid_q[LAT-1];
    assign busy      = |valid_q;
    assign op_in     = valu_op_e'(opcode);

`ifdef VALU_SAT_EN
    assign sat_in = sat;
`else
    assign sat_in = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (advance) begin
            valid_q <= {valid_q[LAT-2:0], in_valid};
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        valu_lane #(
            .WIDTH      (WIDTH),
            .MUL_STAGES (MUL_STAGES)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .en     (advance),
            .op     (op_in),
            .sat    (sat_in),
            .a      (operand1[WIDTH*i +: WIDTH]),
            .b      (operand2[WIDTH*i +: WIDTH]),
            .res_lo (result_lo[WIDTH*i +: WIDTH]),
            .res_hi (result_hi[WIDTH*i +: WIDTH]),
            .cc     (cc[2*i +: 2])
        );
    end

endmodule
